column_selector: RTL and testbench

Parametrised column cursor for the Connect-4 player input path. It conditions the raw left, right and drop buttons (synchronise, debounce, edge-detect, auto-repeat) and moves a column cursor over `NUM_COLS` columns, skipping full columns, with optional wrap-around. Drop requests go to the board/turn controller over a valid/ready handshake. It sits between the board buttons and the board-update logic, and drives the cursor column to the display.

---
 rtl/connect4_pkg.sv | 19 +
 rtl/button_conditioner.sv | 79 +++++++
 rtl/column_selector.sv | 138 +++++++++++++
 tb/tb_column_selector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board width, column type and the drop handshake states.
package connect4_pkg;

  localparam int unsigned NUM_COLS_DEFAULT = 7;
  localparam int unsigned COL_W_DEFAULT    = $clog2(NUM_COLS_DEFAULT);

  typedef logic [COL_W_DEFAULT-1:0] col_t;

  typedef enum logic {
    DROP_IDLE,
    DROP_PEND
  } drop_state_e;

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One raw button: 2-flop synchroniser, debounce counter, rising-edge event and
// optional auto-repeat. REPEAT_DELAY = 0 disables repeat.
module button_conditioner
  import connect4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 1
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = cnt_width(RP_MAX);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic [1:0]      sync_q, sync_d;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [RP_W-1:0] rep_q, rep_d;
  logic            first_q, first_d;
  logic            evt_q, evt_d;
  logic            rep_fire;

  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    deb_d    = deb_q;
    cnt_d    = '0;
    rep_d    = '0;
    first_d  = 1'b1;
    rep_fire = 1'b0;

    // Counting only while the synchronised level differs from the accepted
    // one; a return to the accepted level zeroes the count, i.e. restarts it.
    if (sync_q[1] != deb_q) begin
      if (cnt_q == DB_LAST) deb_d = sync_q[1];
      else                  cnt_d = cnt_q + DB_W'(1);
    end

    if (REPEAT_DELAY != 0 && deb_q && deb_d) begin
      first_d = first_q;
      rep_d   = rep_q + RP_W'(1);
      if (rep_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
        rep_fire = 1'b1;
        rep_d    = '0;
        first_d  = 1'b0;
      end
    end

    evt_d = (deb_d && !deb_q) || rep_fire;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= '0;
      first_q <= 1'b1;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      first_q <= first_d;
      evt_q   <= evt_d;
    end
  end

  assign press_evt = evt_q;

endmodule

// File: rtl/column_selector.sv
// Connect-4 column cursor: conditioned left/right/drop buttons move a cursor over
// non-full columns and issue drop requests on a valid/ready handshake.
module column_selector
  import connect4_pkg::*;
#(
  parameter int unsigned NUM_COLS        = NUM_COLS_DEFAULT,
  parameter int unsigned START_COL       = 3,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  localparam int unsigned COL_W          = $clog2(NUM_COLS)
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                RBTN,
  input  logic                LBTN,
  input  logic                DBTN,
  input  logic                enable,
  input  logic [NUM_COLS-1:0] col_full,
  output logic [COL_W-1:0]    columnPosition,
  output logic                drop_valid,
  output logic [COL_W-1:0]    drop_col,
  input  logic                drop_ready
);

  logic r_evt, l_evt, d_evt;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_rbtn (.clock(clock), .rst(rst), .btn_raw(RBTN), .press_evt(r_evt));

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_lbtn (.clock(clock), .rst(rst), .btn_raw(LBTN), .press_evt(l_evt));

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (0),
    .REPEAT_PERIOD  (1)
  ) u_dbtn (.clock(clock), .rst(rst), .btn_raw(DBTN), .press_evt(d_evt));

  drop_state_e      state_q, state_d;
  logic [COL_W-1:0] cursor_q, cursor_d;
  logic [COL_W-1:0] drop_col_q, drop_col_d;

  logic             r_found, l_found;
  logic [COL_W-1:0] r_tgt, l_tgt;
  int unsigned      cur_i, idx;
  logic             in_range;

  // Nearest free column in each direction; the first hit at the smallest
  // distance wins, wrapped positions only count when WRAP is set.
  always_comb begin
    r_found  = 1'b0;
    l_found  = 1'b0;
    r_tgt    = cursor_q;
    l_tgt    = cursor_q;
    cur_i    = 32'(cursor_q);
    idx      = '0;
    in_range = 1'b0;
    for (int unsigned i = 1; i < NUM_COLS; i++) begin
      idx      = cur_i + i;
      in_range = 1'b1;
      if (idx >= NUM_COLS) begin
        idx      = idx - NUM_COLS;
        in_range = (WRAP != 0);
      end
      if (in_range && !r_found && !col_full[COL_W'(idx)]) begin
        r_found = 1'b1;
        r_tgt   = COL_W'(idx);
      end

      idx      = cur_i + NUM_COLS - i;
      in_range = 1'b1;
      if (idx >= NUM_COLS) idx = idx - NUM_COLS;
      else                 in_range = (WRAP != 0);
      if (in_range && !l_found && !col_full[COL_W'(idx)]) begin
        l_found = 1'b1;
        l_tgt   = COL_W'(idx);
      end
    end
  end

  logic idle, move_r, move_l, move_ok;

  always_comb begin
    idle       = (state_q == DROP_IDLE);
    move_r     = r_evt && !l_evt && enable && idle;
    move_l     = l_evt && !r_evt && enable && idle;
    cursor_d   = cursor_q;
    move_ok    = 1'b0;
    state_d    = state_q;
    drop_col_d = drop_col_q;

    if (move_r && r_found) begin
      cursor_d = r_tgt;
      move_ok  = 1'b1;
    end else if (move_l && l_found) begin
      cursor_d = l_tgt;
      move_ok  = 1'b1;
    end

    case (state_q)
      DROP_IDLE: begin
        if (d_evt && enable && !col_full[cursor_q] && !move_ok) begin
          state_d    = DROP_PEND;
          drop_col_d = cursor_q;
        end
      end
      DROP_PEND: begin
        if (drop_ready) state_d = DROP_IDLE;
      end
      default: state_d = DROP_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= DROP_IDLE;
      cursor_q   <= COL_W'(START_COL);
      drop_col_q <= '0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      drop_col_q <= drop_col_d;
    end
  end

  assign columnPosition = cursor_q;
  assign drop_valid     = (state_q == DROP_PEND);
  assign drop_col       = drop_col_q;

endmodule

// File: tb/tb_column_selector.sv
// Bench for column_selector: directed vector table, cycle-exact sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_column_selector;

  localparam int unsigned N = 7, D = 4, RD = 20, RP = 8, START = 3;
  localparam int NI = 7;

  logic clock = 1'b0, rst = 1'b0;
  logic RBTN = 1'b0, LBTN = 1'b0, DBTN = 1'b0, enable = 1'b1, drop_ready = 1'b0;
  logic [6:0] col_full = '0;
  logic [2:0] pos0, pos1, dcol0, dcol1;
  logic dv0, dv1;

  column_selector #(.NUM_COLS(N), .START_COL(START), .WRAP(0), .DEBOUNCE_CYCLES(D),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut0 (
    .clock(clock), .rst(rst), .RBTN(RBTN), .LBTN(LBTN), .DBTN(DBTN), .enable(enable),
    .col_full(col_full), .columnPosition(pos0), .drop_valid(dv0), .drop_col(dcol0),
    .drop_ready(drop_ready));

  column_selector #(.NUM_COLS(N), .START_COL(START), .WRAP(1), .DEBOUNCE_CYCLES(D),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
    .clock(clock), .rst(rst), .RBTN(RBTN), .LBTN(LBTN), .DBTN(DBTN), .enable(enable),
    .col_full(col_full), .columnPosition(pos1), .drop_valid(dv1), .drop_col(dcol1),
    .drop_ready(drop_ready));

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit hist[3][D+2];     // raw samples, oldest first
  bit m_deb[3];
  int m_held[3];
  bit m_ev[3];
  bit m_raw[3];
  int m_cur[2];
  bit m_pend[2];
  int m_col[2];
  bit all1, all0, was_pend, moved;
  int nc, old_cur;

  function automatic int search(input int cur, input int dir, input bit wrap, input logic [6:0] cf);
    for (int d = 1; d < NI; d++) begin
      int p;
      p = cur + dir * d;
      if (p < 0 || p >= NI) begin
        if (!wrap) break;
        p = (p + NI) % NI;
      end
      if (!cf[p]) return p;
    end
    return cur;
  endfunction

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int j = 0; j < int'(D) + 2; j++) hist[b][j] = 1'b0;
        m_deb[b] = 1'b0; m_held[b] = 0; m_ev[b] = 1'b0;
      end
      for (int w = 0; w < 2; w++) begin
        m_cur[w] = START; m_pend[w] = 1'b0; m_col[w] = 0;
      end
    end else begin
      // cursor / drop respond to the events of the previous cycle
      for (int w = 0; w < 2; w++) begin
        was_pend = m_pend[w];
        old_cur  = m_cur[w];
        moved    = 1'b0;
        if (!was_pend && enable && (m_ev[0] != m_ev[1])) begin
          nc = search(old_cur, m_ev[0] ? 1 : -1, w == 1, col_full);
          if (nc != old_cur) begin
            m_cur[w] = nc;
            moved = 1'b1;
          end
        end
        if (!was_pend && enable && m_ev[2] && !moved && !col_full[old_cur]) begin
          m_pend[w] = 1'b1;
          m_col[w]  = old_cur;
        end
        if (was_pend && drop_ready) m_pend[w] = 1'b0;
      end
      // debounce: accepted level flips once the last D synchronised samples agree
      m_raw[0] = RBTN; m_raw[1] = LBTN; m_raw[2] = DBTN;
      for (int b = 0; b < 3; b++) begin
        for (int j = 0; j < int'(D) + 1; j++) hist[b][j] = hist[b][j+1];
        hist[b][D+1] = m_raw[b];
        all1 = 1'b1; all0 = 1'b1;
        for (int j = 0; j < int'(D); j++) begin
          if (hist[b][j]) all0 = 1'b0;
          else            all1 = 1'b0;
        end
        m_ev[b] = 1'b0;
        if (!m_deb[b] && all1) begin
          m_deb[b] = 1'b1; m_held[b] = 0; m_ev[b] = 1'b1;
        end else if (m_deb[b] && all0) begin
          m_deb[b] = 1'b0;
        end else if (m_deb[b]) begin
          m_held[b]++;
          if (b != 2 && m_held[b] >= int'(RD) && (m_held[b] - int'(RD)) % int'(RP) == 0)
            m_ev[b] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on && !rst) begin
      chk("model_pos_w0",  int'(pos0),  m_cur[0]);
      chk("model_pos_w1",  int'(pos1),  m_cur[1]);
      chk("model_dv_w0",   int'(dv0),   int'(m_pend[0]));
      chk("model_dv_w1",   int'(dv1),   int'(m_pend[1]));
      chk("model_dcol_w0", int'(dcol0), m_col[0]);
      chk("model_dcol_w1", int'(dcol1), m_col[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1; RBTN = 1'b0; LBTN = 1'b0; DBTN = 1'b0;
    enable = 1'b1; drop_ready = 1'b0; col_full = '0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic press(input logic r, input logic l, input logic d, input int hold);
    @(negedge clock);
    RBTN = r; LBTN = l; DBTN = d;
    repeat (hold) @(negedge clock);
    RBTN = 1'b0; LBTN = 1'b0; DBTN = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  typedef struct {
    logic [6:0] cf;
    bit         is_r;
    int         n;
    int         exp0;
    int         exp1;
  } vec_t;

  vec_t vt[8];
  int   rem[3];
  int   exp_c;

  initial begin
    vt[0] = '{7'b0000000, 1'b1, 1, 4, 4};
    vt[1] = '{7'b0000000, 1'b1, 3, 6, 6};
    vt[2] = '{7'b0000000, 1'b1, 4, 6, 0};
    vt[3] = '{7'b0000000, 1'b0, 3, 0, 0};
    vt[4] = '{7'b0000000, 1'b0, 4, 0, 6};
    vt[5] = '{7'b0110000, 1'b1, 1, 6, 6};
    vt[6] = '{7'b1110000, 1'b1, 1, 3, 0};
    vt[7] = '{7'b0000111, 1'b0, 1, 3, 6};

    do_reset();
    #1;
    chk("reset_pos",  int'(pos0),  3);
    chk("reset_dv",   int'(dv0),   0);
    chk("reset_dcol", int'(dcol0), 0);
    chk_on = 1'b1;

    // right press from cycle 0: event in cycle 6, cursor visible in cycle 7
    @(negedge clock);
    RBTN = 1'b1;
    repeat (6) @(posedge clock);
    #1 chk("latency_c6", int'(pos0), 3);
    @(posedge clock);
    #1 chk("latency_c7_w0", int'(pos0), 4);
    chk("latency_c7_w1", int'(pos1), 4);
    repeat (3) @(posedge clock);
    #1 RBTN = 1'b0;
    repeat (12) @(negedge clock);
    RBTN = 1'b1;
    repeat (2) @(negedge clock);
    RBTN = 1'b0;
    repeat (15) @(negedge clock);
    chk("glitch_no_move", int'(pos0), 4);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      col_full = vt[i].cf;
      for (int k = 0; k < vt[i].n; k++) press(vt[i].is_r, !vt[i].is_r, 1'b0, 8);
      chk($sformatf("vec%0d_w0", i), int'(pos0), vt[i].exp0);
      chk($sformatf("vec%0d_w1", i), int'(pos1), vt[i].exp1);
      col_full = '0;
    end

    // auto-repeat: events in cycles 6, 26, 34, 42
    do_reset();
    for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 1'b0, 8);
    chk("repeat_start", int'(pos0), 0);
    @(negedge clock);
    RBTN = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock);
      #1;
      exp_c = (c >= 43) ? 4 : (c >= 35) ? 3 : (c >= 27) ? 2 : (c >= 7) ? 1 : 0;
      chk($sformatf("repeat_c%0d", c), int'(pos1), exp_c);
      if (c == 44) RBTN = 1'b0;
    end

    // drop held off by drop_ready=0; moves ignored while pending
    press(1'b0, 1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 1'b0, 8);
    chk("drop_pre_pos", int'(pos0), 2);
    press(1'b0, 1'b0, 1'b1, 8);
    chk("drop_valid_held", int'(dv0), 1);
    chk("drop_col_held",   int'(dcol1), 2);
    press(1'b1, 1'b0, 1'b0, 8);
    chk("drop_move_ignored", int'(pos0), 2);
    chk("drop_still_valid",  int'(dv1), 1);
    drop_ready = 1'b1;
    @(posedge clock);
    #1 chk("drop_accept_clears", int'(dv0), 0);
    drop_ready = 1'b0;

    // reset mid-handshake acts without a clock edge
    press(1'b0, 1'b0, 1'b1, 8);
    chk("rst_pre_dv", int'(dv0), 1);
    @(negedge clock);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_dv",   int'(dv0),  0);
    chk("rst_async_pos",  int'(pos0), 3);
    chk("rst_async_dcol", int'(dcol0), 0);
    @(negedge clock);
    rst = 1'b0;

    do_reset();
    press(1'b1, 1'b1, 1'b0, 8);
    chk("both_lr_no_move", int'(pos0), 3);
    enable = 1'b0;
    press(1'b0, 1'b0, 1'b1, 8);
    chk("disabled_no_drop", int'(dv0), 0);
    press(1'b1, 1'b0, 1'b0, 8);
    chk("disabled_no_move", int'(pos1), 3);
    enable = 1'b1;

    // randomized run, checked every cycle by the model
    for (int b = 0; b < 3; b++) rem[b] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          case (b)
            0: RBTN = ~RBTN;
            1: LBTN = ~LBTN;
            default: DBTN = ~DBTN;
          endcase
          rem[b] = int'($urandom_range(1, 40));
        end else begin
          rem[b]--;
        end
      end
      if ($urandom_range(0, 49) == 0) col_full = 7'($urandom) & 7'($urandom);
      enable     = ($urandom_range(0, 9) != 0);
      drop_ready = ($urandom_range(0, 3) == 0);
      if (cyc == 1500) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
